// File: rtl/sm_adder_rom_arbiter.sv
// Round-robin front end sharing one ROM-based sign-magnitude adder.
// Issues one operand pair at a time and returns the tagged ROM result.
module sm_adder_rom_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         rom_a,
  output logic [DATA_WIDTH-1:0]         rom_b,
  input  logic [DATA_WIDTH:0]           rom_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [15:0]                   op_count
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOOKUP  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]         state;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               grant_any;
  int                 idx;

  // Scan starts just past the previous winner so every port rotates.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    grant_oh[grant_idx] = grant_any;
  end

  assign req_ready = (state == S_IDLE) ? grant_oh : '0;
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      rom_a      <= '0;
      rom_b      <= '0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            rom_a      <= req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            rom_b      <= req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            rsp_id     <= grant_idx;
            last_grant <= grant_idx;
            state      <= S_LOOKUP;
          end
        end
        // ROM samples {rom_a, rom_b} at the end of this cycle.
        S_LOOKUP: state <= S_CAPTURE;
        S_CAPTURE: begin
          rsp_data <= rom_data;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            op_count <= op_count + 16'd1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sm_adder_rom_arbiter.md
# sm_adder_rom_arbiter

Round-robin arbiter and sequencer that shares one ROM-based 16-bit-address sign-magnitude adder among NUM_REQ requesters. It accepts operand pairs over valid/ready handshakes and drives the adder's a/b inputs. It waits out the adder's one-cycle synchronous ROM read and returns the (DATA_WIDTH+1)-bit sign-magnitude result, tagged with the requester index. It sits between client blocks and the adder instance; the adder itself is external.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, operand width; result is DATA_WIDTH+1 bits
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*DATA_WIDTH  operand A, requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  in  NUM_REQ*DATA_WIDTH  operand B, same packing
- req_ready  out  NUM_REQ  one-hot accept strobe
- rom_a  out  DATA_WIDTH  to adder a input (registered)
- rom_b  out  DATA_WIDTH  to adder b input (registered)
- rom_data  in  DATA_WIDTH+1  adder registered output
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_data  out  DATA_WIDTH+1  result, passed through uninterpreted
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns rsp_data
- op_count  out  16  completed operations, wraps 16'hFFFF -> 0

## Operation
- FSM states: IDLE, LOOKUP, CAPTURE, RESP.
- IDLE: if any req_valid is set, grant g is the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap. req_ready[g]=1 combinationally in this cycle only. On the edge, latch req_a/req_b slice g into rom_a/rom_b, g into rsp_id and last_grant; go to LOOKUP. No valid: stay in IDLE, req_ready=0.
- LOOKUP: rom_a/rom_b stable; the adder samples address {rom_a, rom_b} at the closing edge. Go to CAPTURE unconditionally.
- CAPTURE: rom_data is valid; latch it into rsp_data; go to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_id are held stable. On an edge with rsp_ready=1: op_count increments and the FSM goes to IDLE. Otherwise it stays in RESP.
- req_ready is 0 in every state except IDLE. A requester must hold req_valid and its operands until it sees req_ready; it may drop valid at any time before grant.
- rom_a/rom_b change only on the accept edge and otherwise hold their last value.
- rom_data is ignored outside CAPTURE. The adder has no reset, so post-reset contents of its output register are don't-care.
- Arbitration is work-conserving round-robin: a continuously requesting port waits at most NUM_REQ-1 grants.

## Timing
- Reset (async assert, sync-style release on next clk edge) gives:
  - state=IDLE, req_ready=0, rsp_valid=0
  - rsp_data=0, rsp_id=0, rom_a=0, rom_b=0, op_count=0
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- Latency: accept edge E0 -> rsp_valid high after edge E2 (2 cycles). Minimum issue interval is 4 cycles: IDLE, LOOKUP, CAPTURE, RESP with rsp_ready=1.
- The RESP->IDLE handshake edge and the next grant are never in the same cycle; the next req_ready can assert in the cycle after the handshake.
- Reset in LOOKUP, CAPTURE or RESP discards the in-flight operation: no response, op_count unchanged (0). The requester's accepted transfer is lost.
- Simultaneous rsp_ready and new req_valid in RESP: the response completes, and the request is evaluated in the following IDLE cycle.
- op_count at 16'hFFFF plus one handshake -> 16'h0000.

## Test plan
- Single request: port 2 sends a=8'h05, b=8'h03 with rsp_ready=1 -> req_ready=4'b0100 for 1 cycle, rom_a=8'h05/rom_b=8'h03 next cycle, rsp_valid 2 cycles after accept with rsp_data=ROM model[16'h0503], rsp_id=2, op_count=1.
- All four valid from reset, rsp_ready=1 -> grant order 0,1,2,3,0; responses every 4 cycles with matching rsp_id.
- Fairness: after a grant to 1, ports 0 and 2 valid -> port 2 is granted before port 0.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay constant; req_ready stays 0; op_count increments once when rsp_ready rises.
- Reset mid-CAPTURE: assert rst_n=0 -> all outputs read reset values immediately; no rsp_valid pulse; next request from port 3 is served normally.
- Counter wrap: force 65536 handshakes (or preload via backdoor) -> op_count goes 16'hFFFF -> 16'h0000.
